// File: rtl/ibuff_pkg.sv
// Shared sizing constants and types for the instruction buffer controller.
package ibuff_pkg;

    localparam int DEPTH      = 16;
    localparam int INDEX      = 4;
    localparam int WIDTH      = 8;
    localparam int WR_PORTS   = 4;
    localparam int RD_PORTS   = 4;
    localparam int LANE_CNT_W = $clog2(WR_PORTS + 1);

    typedef logic [INDEX-1:0]      ibuff_ptr_t;
    typedef logic [INDEX:0]        ibuff_cnt_t;
    typedef logic [WR_PORTS-1:0]   ibuff_mask_t;
    typedef logic [LANE_CNT_W-1:0] ibuff_lane_cnt_t;

endpackage

// File: rtl/ibuff_ctrl_if.sv
// Fetch, dispatch and RAM-port bundle between the buffer controller and its neighbours.
interface ibuff_ctrl_if;
    import ibuff_pkg::*;

    logic                      flush_i;
    ibuff_mask_t               fetchValid_i;
    logic [WR_PORTS*WIDTH-1:0] fetchData_i;
    logic                      stall_o;
    ibuff_mask_t               ramWe_o;
    logic [WR_PORTS*INDEX-1:0] ramAddrWr_o;
    logic [WR_PORTS*WIDTH-1:0] ramDataWr_o;
    logic [RD_PORTS*INDEX-1:0] ramAddrRd_o;
    logic                      dispatchValid_o;
    logic                      dispatchReady_i;
    ibuff_cnt_t                count_o;

    modport slave (
        input  flush_i, fetchValid_i, fetchData_i, dispatchReady_i,
        output stall_o, ramWe_o, ramAddrWr_o, ramDataWr_o, ramAddrRd_o,
               dispatchValid_o, count_o
    );

    modport master (
        output flush_i, fetchValid_i, fetchData_i, dispatchReady_i,
        input  stall_o, ramWe_o, ramAddrWr_o, ramDataWr_o, ramAddrRd_o,
               dispatchValid_o, count_o
    );

endinterface

// File: rtl/ibuff_lane_compact.sv
// Packs the valid fetch lanes into consecutive write slots starting at slot 0.
module ibuff_lane_compact
    import ibuff_pkg::*;
(
    input  logic                      enable,
    input  ibuff_mask_t               valid,
    input  logic [WR_PORTS*WIDTH-1:0] data,
    output ibuff_mask_t               we,
    output logic [WR_PORTS*WIDTH-1:0] data_out,
    output ibuff_lane_cnt_t           count
);

    ibuff_lane_cnt_t prefix [WR_PORTS];

    // prefix[i] is the slot a valid lane i lands in: the number of valid lanes below it
    always_comb begin : prefix_scan
        ibuff_lane_cnt_t run;
        run = '0;
        for (int i = 0; i < WR_PORTS; i++) begin
            prefix[i] = run;
            run       = run + ibuff_lane_cnt_t'(valid[i]);
        end
        count = enable ? run : '0;
    end

    always_comb begin
        we       = '0;
        data_out = '0;
        for (int k = 0; k < WR_PORTS; k++) begin
            for (int i = 0; i < WR_PORTS; i++) begin
                if (enable && valid[i] && (prefix[i] == ibuff_lane_cnt_t'(k))) begin
                    we[k]                      = 1'b1;
                    data_out[k*WIDTH +: WIDTH] = data[i*WIDTH +: WIDTH];
                end
            end
        end
    end

endmodule

// File: rtl/ibuff_ctrl.sv
// Head/tail/occupancy controller for the circular instruction buffer RAM.
module ibuff_ctrl
    import ibuff_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    ibuff_ctrl_if.slave  bus
);

    ibuff_ptr_t      head;
    ibuff_ptr_t      tail;
    ibuff_cnt_t      count;
    logic            stall;
    logic            push;
    logic            pop;
    logic            dispatch_valid;
    ibuff_lane_cnt_t push_n;
    ibuff_mask_t     we;
    logic [WR_PORTS*WIDTH-1:0] data_wr;
    logic [WR_PORTS*INDEX-1:0] addr_wr;
    logic [RD_PORTS*INDEX-1:0] addr_rd;

    // Stall looks only at free space, never at the mask, so fetch sees a stable decision
    assign stall          = (ibuff_cnt_t'(DEPTH) - count) < ibuff_cnt_t'(WR_PORTS);
    assign push           = reset && !stall && !bus.flush_i;
    assign dispatch_valid = count >= ibuff_cnt_t'(RD_PORTS);
    assign pop            = dispatch_valid && bus.dispatchReady_i && !bus.flush_i;

    ibuff_lane_compact u_compact (
        .enable   (push),
        .valid    (bus.fetchValid_i),
        .data     (bus.fetchData_i),
        .we       (we),
        .data_out (data_wr),
        .count    (push_n)
    );

    always_comb begin
        addr_wr = '0;
        addr_rd = '0;
        for (int k = 0; k < WR_PORTS; k++) begin
            addr_wr[k*INDEX +: INDEX] = tail + ibuff_ptr_t'(k);
        end
        for (int j = 0; j < RD_PORTS; j++) begin
            addr_rd[j*INDEX +: INDEX] = head + ibuff_ptr_t'(j);
        end
    end

    assign bus.stall_o         = stall;
    assign bus.ramWe_o         = we;
    assign bus.ramAddrWr_o     = addr_wr;
    assign bus.ramDataWr_o     = data_wr;
    assign bus.ramAddrRd_o     = addr_rd;
    assign bus.dispatchValid_o = dispatch_valid;
    assign bus.count_o         = count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (bus.flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            tail  <= tail + ibuff_ptr_t'(push_n);
            if (pop) begin
                head <= head + ibuff_ptr_t'(RD_PORTS);
            end
            count <= count + ibuff_cnt_t'(push_n) - (pop ? ibuff_cnt_t'(RD_PORTS) : ibuff_cnt_t'(0));
        end
    end

    count_in_range : assert property (@(posedge clk) disable iff (!reset)
        count <= ibuff_cnt_t'(DEPTH));

endmodule

// File: tb/tb_ibuff_ctrl.sv
// Self-checking bench: FIFO queue model compared every cycle plus directed literal checks.
module tb_ibuff_ctrl;
    import ibuff_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    ibuff_ctrl_if bus ();

    ibuff_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] ram [DEPTH];
    logic [WIDTH-1:0] fifoQ [$];
    logic [WIDTH-1:0] laneData [$];
    int mHead = 0;
    int mTail = 0;

    logic                      doPush;
    logic                      doPop;
    ibuff_mask_t               expWe;
    logic [WR_PORTS*INDEX-1:0] expAddrWr;
    logic [WR_PORTS*WIDTH-1:0] expDataWr;
    logic [RD_PORTS*INDEX-1:0] expAddrRd;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input ibuff_mask_t mask, input logic [WR_PORTS*WIDTH-1:0] data,
                                 input logic ready, input logic flush);
        bus.fetchValid_i    = mask;
        bus.fetchData_i     = data;
        bus.dispatchReady_i = ready;
        bus.flush_i         = flush;
        #2;
    endtask

    task automatic stepClock();
        @(posedge clk);
        #2;
    endtask

    // Queue model: the buffer is a FIFO of instruction bytes; everything else follows from its size
    always @(negedge clk) begin
        if (!reset) begin
            fifoQ.delete();
            mHead = 0;
            mTail = 0;
            checkOutput("rst_count", 64'(bus.count_o), 64'(0));
            checkOutput("rst_we", 64'(bus.ramWe_o), 64'(0));
            checkOutput("rst_valid", 64'(bus.dispatchValid_o), 64'(0));
        end else begin
            doPush = ((DEPTH - fifoQ.size()) >= WR_PORTS) && !bus.flush_i;
            doPop  = (fifoQ.size() >= RD_PORTS) && bus.dispatchReady_i && !bus.flush_i;
            laneData.delete();
            for (int i = 0; i < WR_PORTS; i++) begin
                if (bus.fetchValid_i[i]) laneData.push_back(bus.fetchData_i[i*WIDTH +: WIDTH]);
            end
            expWe     = '0;
            expDataWr = '0;
            for (int k = 0; k < WR_PORTS; k++) begin
                expAddrWr[k*INDEX +: INDEX] = INDEX'((mTail + k) % DEPTH);
                if (doPush && k < laneData.size()) begin
                    expWe[k]                    = 1'b1;
                    expDataWr[k*WIDTH +: WIDTH] = laneData[k];
                end
            end
            for (int j = 0; j < RD_PORTS; j++) begin
                expAddrRd[j*INDEX +: INDEX] = INDEX'((mHead + j) % DEPTH);
            end

            checkOutput("count", 64'(bus.count_o), 64'(fifoQ.size()));
            checkOutput("stall", 64'(bus.stall_o), 64'(!((DEPTH - fifoQ.size()) >= WR_PORTS)));
            checkOutput("dispatch_valid", 64'(bus.dispatchValid_o), 64'(fifoQ.size() >= RD_PORTS));
            checkOutput("ram_we", 64'(bus.ramWe_o), 64'(expWe));
            checkOutput("ram_addr_wr", 64'(bus.ramAddrWr_o), 64'(expAddrWr));
            checkOutput("ram_data_wr", 64'(bus.ramDataWr_o), 64'(expDataWr));
            checkOutput("ram_addr_rd", 64'(bus.ramAddrRd_o), 64'(expAddrRd));

            if (doPop) begin
                for (int j = 0; j < RD_PORTS; j++) begin
                    checkOutput("pop_data", 64'(ram[bus.ramAddrRd_o[j*INDEX +: INDEX]]), 64'(fifoQ[j]));
                end
            end

            for (int k = 0; k < WR_PORTS; k++) begin
                if (bus.ramWe_o[k]) ram[bus.ramAddrWr_o[k*INDEX +: INDEX]] = bus.ramDataWr_o[k*WIDTH +: WIDTH];
            end

            if (bus.flush_i) begin
                fifoQ.delete();
                mHead = 0;
                mTail = 0;
            end else begin
                if (doPop) begin
                    repeat (RD_PORTS) void'(fifoQ.pop_front());
                    mHead = (mHead + RD_PORTS) % DEPTH;
                end
                if (doPush) begin
                    foreach (laneData[i]) fifoQ.push_back(laneData[i]);
                    mTail = (mTail + laneData.size()) % DEPTH;
                end
            end
        end
    end

    initial begin
        reset               = 1'b0;
        bus.flush_i         = 1'b0;
        bus.fetchValid_i    = 4'hF;
        bus.fetchData_i     = 32'hDEADBEEF;
        bus.dispatchReady_i = 1'b0;
        #2;
        checkOutput("reset_we", 64'(bus.ramWe_o), 64'(0));
        checkOutput("reset_count", 64'(bus.count_o), 64'(0));
        checkOutput("reset_stall", 64'(bus.stall_o), 64'(0));
        checkOutput("reset_addr_rd", 64'(bus.ramAddrRd_o), 64'h3210);
        stepClock();
        bus.fetchValid_i = '0;
        reset            = 1'b1;

        // fill to full, then a stalled push is dropped
        for (int n = 1; n <= 4; n++) begin
            applyStimulus(4'hF, 32'(32'h03020100 + 32'h10101010 * n), 1'b0, 1'b0);
            checkOutput("fill_stall_pre", 64'(bus.stall_o), 64'(0));
            stepClock();
            checkOutput("fill_count", 64'(bus.count_o), 64'(n * 4));
        end
        checkOutput("full_stall", 64'(bus.stall_o), 64'(1));
        checkOutput("full_we", 64'(bus.ramWe_o), 64'(0));
        stepClock();
        checkOutput("full_count_hold", 64'(bus.count_o), 64'(16));
        repeat (4) begin
            applyStimulus(4'h0, 32'h0, 1'b1, 1'b0);
            stepClock();
        end
        checkOutput("drain_count", 64'(bus.count_o), 64'(0));

        // sparse mask compaction
        applyStimulus(4'b1010, 32'hB366A155, 1'b0, 1'b0);
        checkOutput("compact_we", 64'(bus.ramWe_o), 64'h3);
        checkOutput("compact_addr", 64'(bus.ramAddrWr_o), 64'h3210);
        checkOutput("compact_data", 64'(bus.ramDataWr_o), 64'h0000B3A1);
        stepClock();
        checkOutput("compact_count", 64'(bus.count_o), 64'(2));

        // partial bundle is never dispatched
        applyStimulus(4'b0001, 32'h000000C0, 1'b0, 1'b0);
        checkOutput("tail2_addr", 64'(bus.ramAddrWr_o), 64'h5432);
        stepClock();
        applyStimulus(4'h0, 32'h0, 1'b1, 1'b0);
        checkOutput("partial_valid", 64'(bus.dispatchValid_o), 64'(0));
        stepClock();
        checkOutput("partial_count", 64'(bus.count_o), 64'(3));
        applyStimulus(4'b0100, 32'h00D20000, 1'b0, 1'b0);
        stepClock();
        checkOutput("four_count", 64'(bus.count_o), 64'(4));
        checkOutput("four_valid", 64'(bus.dispatchValid_o), 64'(1));
        checkOutput("four_addr_rd", 64'(bus.ramAddrRd_o), 64'h3210);
        applyStimulus(4'h0, 32'h0, 1'b1, 1'b0);
        stepClock();
        checkOutput("four_pop_count", 64'(bus.count_o), 64'(0));

        // write-pointer wrap at tail 14, read pointer wraps 12 -> 0
        applyStimulus(4'b0011, 32'h00002221, 1'b0, 1'b0);
        stepClock();
        applyStimulus(4'hF, 32'h33323130, 1'b0, 1'b0);
        stepClock();
        applyStimulus(4'hF, 32'h43424140, 1'b1, 1'b0);
        stepClock();
        applyStimulus(4'h0, 32'h0, 1'b1, 1'b0);
        stepClock();
        applyStimulus(4'hF, 32'h53525150, 1'b0, 1'b0);
        checkOutput("wrap_addr_wr", 64'(bus.ramAddrWr_o), 64'h10FE);
        checkOutput("wrap_we", 64'(bus.ramWe_o), 64'hF);
        stepClock();
        checkOutput("wrap_count", 64'(bus.count_o), 64'(6));
        checkOutput("wrap_addr_rd", 64'(bus.ramAddrRd_o), 64'hFEDC);
        applyStimulus(4'h0, 32'h0, 1'b1, 1'b0);
        stepClock();
        checkOutput("wrap_head", 64'(bus.ramAddrRd_o), 64'h3210);
        checkOutput("wrap_pop_count", 64'(bus.count_o), 64'(2));

        // simultaneous push and pop at count 8
        applyStimulus(4'hF, 32'h63626160, 1'b0, 1'b0);
        stepClock();
        applyStimulus(4'b0011, 32'h00006766, 1'b0, 1'b0);
        stepClock();
        checkOutput("both_pre_count", 64'(bus.count_o), 64'(8));
        applyStimulus(4'hF, 32'h73727170, 1'b1, 1'b0);
        checkOutput("both_we", 64'(bus.ramWe_o), 64'hF);
        checkOutput("both_addr_wr", 64'(bus.ramAddrWr_o), 64'hBA98);
        stepClock();
        checkOutput("both_count", 64'(bus.count_o), 64'(8));
        checkOutput("both_addr_rd", 64'(bus.ramAddrRd_o), 64'h7654);
        applyStimulus(4'h0, 32'h0, 1'b0, 1'b0);
        checkOutput("both_tail", 64'(bus.ramAddrWr_o), 64'hFEDC);

        // flush wins over push and pop
        applyStimulus(4'hF, 32'h83828180, 1'b1, 1'b1);
        checkOutput("flush_we", 64'(bus.ramWe_o), 64'(0));
        stepClock();
        checkOutput("flush_count", 64'(bus.count_o), 64'(0));
        checkOutput("flush_addr_rd", 64'(bus.ramAddrRd_o), 64'h3210);
        applyStimulus(4'hF, 32'h93929190, 1'b0, 1'b0);
        checkOutput("flush_tail", 64'(bus.ramAddrWr_o), 64'h3210);
        stepClock();
        checkOutput("post_flush_count", 64'(bus.count_o), 64'(4));

        // asynchronous reset mid-push, checked before any clock edge
        reset = 1'b0;
        #1;
        checkOutput("async_count", 64'(bus.count_o), 64'(0));
        checkOutput("async_we", 64'(bus.ramWe_o), 64'(0));
        checkOutput("async_valid", 64'(bus.dispatchValid_o), 64'(0));
        checkOutput("async_stall", 64'(bus.stall_o), 64'(0));
        checkOutput("async_addr_rd", 64'(bus.ramAddrRd_o), 64'h3210);
        bus.fetchValid_i = '0;
        stepClock();
        reset = 1'b1;
        stepClock();
        checkOutput("final_count", 64'(bus.count_o), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ibuff_ctrl.md
Name: ibuff_ctrl

Overview:
- Pointer and occupancy controller for the instruction buffer RAM (a circular FIFO).
- Fetch side: takes a bundle of up to WR_PORTS instructions with a per-lane valid mask. It compacts the valid lanes and drives the RAM write ports (address, data, write enable).
- Dispatch side: drives the RAM read addresses and presents an all-or-nothing bundle of RD_PORTS instructions through a valid/ready handshake.
- Also handles fetch back-pressure and pipeline flush on recovery.

Parameters:
- DEPTH, 16, buffer entries; must be a power of 2 and >= WR_PORTS + RD_PORTS.
- INDEX, 4, log2(DEPTH); width of RAM address and pointers.
- WIDTH, 8, instruction packet width in bits.
- WR_PORTS, 4, RAM write ports (2*FETCH_WIDTH).
- RD_PORTS, 4, RAM read ports (DISPATCH_WIDTH).

Ports:
- clk  in  1  clock; all state on posedge.
- reset  in  1  asynchronous, active-low reset (already decided).
- flush_i  in  1  recovery flush; empties the buffer.
- fetchValid_i  in  WR_PORTS  per-lane instruction valid mask.
- fetchData_i  in  WR_PORTS*WIDTH  lane-ordered instruction packets.
- stall_o  out  1  fetch back-pressure; while high, the bundle is not accepted.
- ramWe_o  out  WR_PORTS  RAM write enables, compacted from lane 0 upward.
- ramAddrWr_o  out  WR_PORTS*INDEX  RAM write addresses.
- ramDataWr_o  out  WR_PORTS*WIDTH  RAM write data.
- ramAddrRd_o  out  RD_PORTS*INDEX  RAM read addresses; read data returns combinationally from the RAM.
- dispatchValid_o  out  1  RD_PORTS instructions are available at the read addresses.
- dispatchReady_i  in  1  dispatch consumes the bundle this cycle.
- count_o  out  INDEX+1  current occupancy.

Behaviour:
- State is head, tail (INDEX bits each) and count (INDEX+1 bits). All three are 0 on reset assertion, immediately (asynchronous).
- While reset is low, ramWe_o=0 and all other outputs equal their zero-state values: stall_o=0, dispatchValid_o=0, count_o=0, read addresses 0..RD_PORTS-1.
- stall_o = (DEPTH - count) < WR_PORTS. It is combinational from registered count, so it is conservative regardless of the mask.
- push = !stall_o && !flush_i. pushN = popcount(fetchValid_i) when push, else 0.
- Compaction: the k-th set bit of fetchValid_i (counting from lane 0) maps to output slot k.
  - ramWe_o[k] = push && (k < pushN).
  - ramAddrWr_o[k] = tail + k, mod DEPTH (natural INDEX-bit wrap).
  - ramDataWr_o[k] = the data of that lane. Unused slots drive data 0.
- ramAddrRd_o[j] = head + j, mod DEPTH, for j = 0..RD_PORTS-1.
- dispatchValid_o = (count >= RD_PORTS). The bundle is all-or-nothing, so a partial bundle is never presented.
- pop = dispatchValid_o && dispatchReady_i && !flush_i. popN = RD_PORTS when pop, else 0.
- There is no write-to-read bypass: entries pushed in cycle t are first visible to dispatch in cycle t+1 (latency 1).
- Next state: tail += pushN; head += popN; count = count + pushN - popN. Simultaneous push and pop are legal.
- flush_i has priority over push and pop. Next cycle head=tail=count=0, and ramWe_o is 0 in the flush cycle.
- dispatchReady_i asserted while dispatchValid_o=0 is ignored.
- A fetch mask presented while stall_o=1 is dropped; fetch must hold it.
- Count never exceeds DEPTH and never underflows by construction. An assertion checks 0 <= count <= DEPTH.

Decomposition:
- Package ibuff_pkg holds: ibuff_ptr_t (INDEX bits), ibuff_cnt_t (INDEX+1 bits), and a lane-mask typedef sized by WR_PORTS.
- Sub-module ibuff_lane_compact (combinational): computes a per-lane prefix popcount, then builds the slot-to-lane select and the compacted we/data.
- ibuff_ctrl contains the pointers, counter, handshake and flush logic.

Test Plan:
All scenarios use default parameters (DEPTH=16, WR_PORTS=4, RD_PORTS=4).
1. Reset low, then high; push mask 4'b1111 for 4 cycles with dispatchReady_i=0 -> count 4,8,12,16. stall_o=0 until count=16, then stall_o=1. A fifth push is dropped and count stays 16.
2. From empty (tail=0), push mask 4'b1010 with data lane1=0xA1, lane3=0xB3 -> ramWe_o=4'b0011, slot0 addr 0 data 0xA1, slot1 addr 1 data 0xB3. Next cycle tail=2, count=2.
3. count=3 -> dispatchValid_o=0 even with dispatchReady_i=1, and count stays 3. Push 1 instruction -> next cycle count=4, dispatchValid_o=1, ramAddrRd_o = head..head+3.
4. Wrap: drive head=tail=14 by pushing and popping; push 4 -> write addresses 14,15,0,1, tail=2. Dispatch -> read addresses 14,15,0,1, head=2, count=0.
5. count=8, push 4'b1111 and pop in the same cycle -> count stays 8; head and tail both advance by 4.
6. count=8, flush_i=1 with a full push and dispatchReady_i=1 -> ramWe_o=0 that cycle; next cycle count=0, head=tail=0. Separately, assert reset mid-push -> state and outputs zero immediately, without waiting for a clock edge.
